spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command sequencer for the byte-level SPI slave. It sits between the slave's `done`/`dout`/`din` byte interface and a register bank. It decodes the first byte of each frame as a read/write command with a start address, then either writes the following bytes into consecutive registers or pre-fetches consecutive registers into `din` for transmission. It also tracks frame boundaries from `ss` and flags byte overruns.

## Interface
- `ADDR_W`, 7: register address width; the command byte carries bits [ADDR_W-1:0], with ADDR_W ≤ 7.
- `STATUS_BYTE`, 8'hA5: byte driven on `din` while idle and during the command byte and the read dummy byte.
- `clk` in 1: system clock, shared with the SPI slave.
- `rst` in 1: synchronous, active-high reset.
- `ss` in 1: raw slave select, active low, asynchronous; this block synchronizes it internally.
- `done` in 1: one-cycle pulse from the slave when a byte completes.
- `dout` in 8: byte received by the slave; valid in the `done` cycle.
- `din` out 8: byte the slave loads for its next transmission.
- `reg_addr` out ADDR_W: register address.
- `reg_wdata` out 8: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid the cycle after `reg_re`.
- `busy` out 1: high while a frame is active (any state other than SYNC and IDLE).
- `overrun` out 1: sticky; a `done` arrived while a fetch was in progress. Cleared only by `rst`.

## Operation
- **Frame framing.** `ss` passes through a 2-flop synchronizer to give `ss_s`.
  - A frame starts when `ss_s` is low in IDLE.
  - A frame ends when `ss_s` is high in any state.
- **Command byte.** The first byte of a frame is the command: bit7 = 1 selects read, bit7 = 0 selects write, and bits[ADDR_W-1:0] give the start address A.
- **Write frames.** Each subsequent `done` pulses `reg_we`, with `reg_addr` = the current address and `reg_wdata` = `dout`. The address then advances.
- **Read frames.**
  - When the command `done` arrives, issue `reg_re` at A.
  - One cycle later, register `reg_rdata` into `din` and advance the address.
  - The slave loads `din` at the end of the next byte. MISO byte 2 is therefore `STATUS_BYTE` (dummy), and byte 3 onward carry A, A+1, and so on.
  - Each later `done` triggers the next fetch.
  - MOSI bytes during a read frame are ignored.
- **States:**
  - SYNC goes to IDLE when `ss_s` = 1. This is the reset state, so a frame already in progress at reset is discarded.
  - IDLE goes to CMD when `ss_s` = 0.
  - CMD goes to WR or RD_FETCH on `done`, according to bit7.
  - WR stays in WR; it pulses the write on each `done`.
  - RD_FETCH goes to RD_LATCH, with `reg_re` = 1.
  - RD_LATCH goes to RD_WAIT, loading `din` <= `reg_rdata`.
  - RD_WAIT goes to RD_FETCH on `done`.
  - Any state goes to IDLE when `ss_s` = 1, except SYNC, which stays until `ss_s` = 1.
- **Address arithmetic.** The address is ADDR_W bits and increments modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- **On return to IDLE:** `din` <= `STATUS_BYTE`, and the address is left as is (don't care).

## Timing
- **Reset values:**
  - `din` = `STATUS_BYTE`
  - `reg_addr` = 0
  - `reg_wdata` = 0
  - `reg_we` = 0
  - `reg_re` = 0
  - `busy` = 0
  - `overrun` = 0
  - state = SYNC
- **Write latency.** `reg_we` asserts the cycle after the `done` cycle.
- **Read latency.** From `done` to `din` updated is 2 cycles. The SPI byte period must be ≥ 4 clk; the slave's oversampling guarantees ≥ 16.
- **Overrun.** A `done` in RD_FETCH or RD_LATCH sets `overrun`. The fetch completes, and the extra `done` is dropped.
- **`done` coinciding with `ss_s` rising.** The `done` is honoured first: the write is performed, or the fetch is skipped. The state is IDLE the following cycle.
- **`ss` glitch shorter than 2 clk.** May be missed. A frame requires `ss` low for ≥ 2 clk before the first SCK edge.
- **Reset mid-frame.** Any pending `reg_we`/`reg_re` is cancelled, and the block waits in SYNC for `ss` to go high.

## Configuration
- `SPI_REG_AUTOINC_EN`
  - **Defined:** the address increments after every write or fetch, as described above.
  - **Undefined:** the address holds at A for the whole frame. Repeated writes hit the same register and repeated reads re-fetch A, for FIFO-style access.

## Structure
- **Package `spi_reg_pkg`:**
  - state enum (SYNC, IDLE, CMD, WR, RD_FETCH, RD_LATCH, RD_WAIT)
  - `CMD_RD_BIT` = 7
  - default `STATUS_BYTE`
- **Sub-module `spi_ss_sync`:** 2-flop synchronizer, resetting to 1 (deselected).

## Test plan
- **Write burst.** Frame with bytes 0x05, 0x11, 0x22, 0x33 → `reg_we` with (addr 5, 0x11), (6, 0x22), (7, 0x33); `busy` falls 3 cycles after `ss` rises.
- **Read burst.** Registers 0x10..0x12 = 0xDE, 0xAD, 0xBE. Frame 0x90 followed by 4 dummy bytes → MISO reads 0xA5, 0xA5, 0xDE, 0xAD, 0xBE.
- **Wrap.** With ADDR_W = 7, write command 0x7F followed by 2 bytes → writes at addresses 0x7F then 0x00.
- **Macro undefined.** Write 0x03 followed by 0xAA, 0xBB → both writes to address 3.
- **Overrun.** Inject `done` one cycle after a read `done` → `overrun` = 1 and sticky; 1 `reg_re` only.
- **Reset mid-frame.** Assert `rst` during a write frame with `ss` held low → no `reg_we` until `ss` goes high and a new frame starts.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register command sequencer.
// The address auto-increment feature is selected with SPI_REG_AUTOINC_EN (see spi_reg_ctrl).
package spi_reg_pkg;

  // Sequencer states; SYNC is the reset state and waits for a clean deselect.
  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    IDLE     = 3'd1,
    CMD      = 3'd2,
    WR       = 3'd3,
    RD_FETCH = 3'd4,
    RD_LATCH = 3'd5,
    RD_WAIT  = 3'd6
  } state_e;

  // Command byte bit that selects a read frame (1) or a write frame (0).
  localparam int CMD_RD_BIT = 7;

  // Byte presented on MISO while idle, during the command byte and the read dummy byte.
  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

  // Default register address width carried in the command byte.
  localparam int ADDR_W_DEFAULT = 7;

endpackage

// File: rtl/spi_ss_sync.sv
// spi_ss_sync: two-flop synchronizer for the raw, active-low slave select.
// Resets to 1 so the block starts out deselected.
module spi_ss_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss_async,
  output logic ss_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw select into the two-stage chain.
  always_comb begin
    sync_d = {sync_q[0], ss_async};
  end

  // Synchronizer flops, forced to the deselected level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign ss_sync = sync_q[1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer between a byte-level SPI slave and a register bank.
// First byte of a frame = command (bit7 read/write, low bits start address); following
// bytes are written to, or pre-fetched from, the register bank.
// Optional feature macro: SPI_REG_AUTOINC_EN -- when defined the address advances after
// every write or fetch; when undefined the address holds for FIFO-style access.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              done,
  input  logic [7:0]        dout,
  output logic [7:0]        din,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              overrun
);

  logic ss_s;

  spi_ss_sync u_ss_sync (
    .clk      (clk),
    .rst      (rst),
    .ss_async (ss),
    .ss_sync  (ss_s)
  );

  state_e            state_q,   state_d;
  logic [7:0]        din_q,     din_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [7:0]        wdata_q,   wdata_d;
  logic              we_q,      we_d;
  logic              re_q,      re_d;
  logic              busy_q,    busy_d;
  logic              overrun_q, overrun_d;
  // The synchronizer output is forced high during reset; settle_q marks when it
  // again reflects the real pin, so SYNC cannot mistake that reset value for a
  // deselect and re-enter a frame that was already in progress.
  logic [1:0]        settle_q,  settle_d;

  // Address step used after each write and each fetch.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_AUTOINC_EN
    return a + 1'b1;
`else
    return a;
`endif
  endfunction

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    overrun_d = overrun_q;
    settle_d  = {settle_q[0], 1'b1};

    // The write strobe goes out with the current address; advance once it has.
    if (we_q) begin
      addr_d = addr_step(addr_q);
    end

    case (state_q)
      SYNC: begin
        if (settle_q[1] && ss_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        din_d = STATUS_BYTE;
        if (!ss_s) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (done) begin
          addr_d = dout[ADDR_W-1:0];
          if (dout[CMD_RD_BIT]) begin
            // A read command that coincides with deselect skips its fetch.
            if (!ss_s) begin
              re_d    = 1'b1;
              state_d = RD_FETCH;
            end
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        if (done) begin
          we_d    = 1'b1;
          wdata_d = dout;
        end
      end
      RD_FETCH: begin
        if (done) begin
          overrun_d = 1'b1;
        end
        state_d = RD_LATCH;
      end
      RD_LATCH: begin
        if (done) begin
          overrun_d = 1'b1;
        end
        din_d   = reg_rdata;
        addr_d  = addr_step(addr_q);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (done && !ss_s) begin
          re_d    = 1'b1;
          state_d = RD_FETCH;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // Deselect ends any frame; a write in this same cycle has already been taken above.
    if (ss_s && (state_q != SYNC)) begin
      state_d = IDLE;
      din_d   = STATUS_BYTE;
    end

    busy_d = !((state_d == SYNC) || (state_d == IDLE));
  end

  // State and registered outputs; reset discards any frame and pending strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      din_q     <= STATUS_BYTE;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      settle_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      settle_q  <= settle_d;
    end
  end

  assign din       = din_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed bench for spi_reg_ctrl with a simple register bank model.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_AUTOINC_EN
  localparam int INC = 1;
  localparam logic [7:0] RD_EXP0 = 8'hDE;
  localparam logic [7:0] RD_EXP1 = 8'hAD;
  localparam logic [7:0] RD_EXP2 = 8'hBE;
`else
  localparam int INC = 0;
  localparam logic [7:0] RD_EXP0 = 8'hDE;
  localparam logic [7:0] RD_EXP1 = 8'hDE;
  localparam logic [7:0] RD_EXP2 = 8'hDE;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b1;
  logic       done = 1'b0;
  logic [7:0] dout = 8'h00;
  logic [7:0] din;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .done      (done),
    .dout      (dout),
    .din       (din),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Register bank: read data valid the cycle after reg_re.
  logic [7:0] bank [0:127];
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= bank[reg_addr];
  end

  // Monitors: write strobes, read strobes and the byte the slave would load at each done.
  logic [14:0] wr_log [$];
  logic [7:0]  miso_log [$];
  int          re_cnt = 0;
  always @(negedge clk) begin
    if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_cnt++;
    if (done && !ss) miso_log.push_back(din);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int wr_rd   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    ss = 1'b0;
    repeat (4) tick();
  endtask

  task automatic end_frame();
    ss = 1'b1;
    repeat (6) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    dout = b;
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (15) tick();
  endtask

  task automatic expect_write(input string tag, input logic [6:0] a, input logic [7:0] d);
    chk({tag, "_seen"}, 32'(wr_log.size() > wr_rd), 32'd1);
    if (wr_log.size() > wr_rd) begin
      chk({tag, "_addr"}, 32'(wr_log[wr_rd][14:8]), 32'(a));
      chk({tag, "_data"}, 32'(wr_log[wr_rd][7:0]), 32'(d));
      wr_rd++;
    end
  endtask

  int mr;
  int re_base;

  initial begin
    for (int i = 0; i < 128; i++) bank[i] = 8'h00;
    bank[16] = 8'hDE;
    bank[17] = 8'hAD;
    bank[18] = 8'hBE;
    bank[19] = 8'hEF;

    // Reset values
    repeat (3) tick();
    chk("rst_din",     32'(din),       32'hA5);
    chk("rst_addr",    32'(reg_addr),  32'h0);
    chk("rst_wdata",   32'(reg_wdata), 32'h0);
    chk("rst_we",      32'(reg_we),    32'h0);
    chk("rst_re",      32'(reg_re),    32'h0);
    chk("rst_busy",    32'(busy),      32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    rst = 1'b0;
    repeat (5) tick();

    // Write burst 05 11 22 33
    start_frame();
    chk("wb_busy_in", 32'(busy), 32'h1);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    expect_write("wb0", 7'h05, 8'h11);
    expect_write("wb1", 7'(5 + INC), 8'h22);
    expect_write("wb2", 7'(5 + 2 * INC), 8'h33);
    ss = 1'b1;
    repeat (3) @(negedge clk);
    chk("wb_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    chk("wb_busy_fall", 32'(busy), 32'h0);
    repeat (6) tick();
    chk("wb_no_extra", 32'(wr_log.size() - wr_rd), 32'd0);

    // Read burst 90 + 4 dummies
    start_frame();
    chk("rb_miso0", 32'(din), 32'hA5);
    mr = miso_log.size();
    send_byte(8'h90);
    repeat (4) send_byte(8'h00);
    chk("rb_count", 32'(miso_log.size() - mr), 32'd5);
    if (miso_log.size() - mr >= 4) begin
      chk("rb_miso1", 32'(miso_log[mr]),     32'hA5);
      chk("rb_miso2", 32'(miso_log[mr + 1]), 32'(RD_EXP0));
      chk("rb_miso3", 32'(miso_log[mr + 2]), 32'(RD_EXP1));
      chk("rb_miso4", 32'(miso_log[mr + 3]), 32'(RD_EXP2));
    end
    chk("rb_no_write", 32'(wr_log.size() - wr_rd), 32'd0);
    end_frame();
    chk("rb_din_idle", 32'(din), 32'hA5);

    // Address wrap 7F 01 02
    start_frame();
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h02);
    end_frame();
    expect_write("wrap0", 7'h7F, 8'h01);
    expect_write("wrap1", 7'(8'h7F + INC), 8'h02);

    // Hold/increment check 03 AA BB
    start_frame();
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_frame();
    expect_write("hold0", 7'h03, 8'hAA);
    expect_write("hold1", 7'(3 + INC), 8'hBB);

    // Overrun: second done one cycle after the read command done
    chk("ovr_pre", 32'(overrun), 32'h0);
    re_base = re_cnt;
    start_frame();
    dout = 8'h90;
    done = 1'b1;
    tick();
    dout = 8'h00;
    tick();
    done = 1'b0;
    repeat (15) tick();
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_one_re", 32'(re_cnt - re_base), 32'd1);
    end_frame();
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Reset mid-frame with ss held low
    start_frame();
    send_byte(8'h05);
    send_byte(8'h11);
    expect_write("rmf0", 7'h05, 8'h11);
    dout = 8'h22;
    done = 1'b1;
    rst  = 1'b1;
    tick();
    done = 1'b0;
    chk("rmf_we_cancel", 32'(reg_we), 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("rmf_busy_sync", 32'(busy), 32'h0);
    chk("rmf_ovr_clr", 32'(overrun), 32'h0);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("rmf_no_write", 32'(wr_log.size() - wr_rd), 32'd0);
    chk("rmf_busy_held", 32'(busy), 32'h0);
    end_frame();
    start_frame();
    send_byte(8'h04);
    send_byte(8'h77);
    end_frame();
    expect_write("rmf1", 7'h04, 8'h77);
    chk("rmf_no_extra", 32'(wr_log.size() - wr_rd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
